pipeline_hazard_ctl: RTL



---
 rtl/pipeline_hazard_ctl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctl.sv
// Pipeline hazard and sequencing controller.
// Detects load-use hazards, sequences branch flushes and halt/resume, and
// keeps saturating stall/flush event counters.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_RUN   | normal issue; reacts to halt_req, br_taken, load-use hazard
//   S_FLUSH | trailing flush cycles after a taken branch (r_frem left)
//   S_HALT  | pipeline frozen until resume
module pipeline_hazard_ctl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_rs_valid,
  input  logic [2:0]       id_rs,
  input  logic             id_rt_valid,
  input  logic [2:0]       id_rt,
  input  logic             ex_memread,
  input  logic [2:0]       ex_rd,
  input  logic             br_taken,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_we,
  output logic             p1_we,
  output logic             p2_bubble,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // Remaining flush cycles loaded on a taken branch (the branch cycle itself
  // is the first flush cycle).
  localparam logic [2:0] FREM_INIT = 3'(FLUSH_CYCLES - 1);

  state_t           r_state;
  logic [2:0]       r_frem;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_luh;
  logic w_stall_max;
  logic w_flush_max;

  // Load-use hazard: phase-2 reads a register the phase-3 load writes (r0 included).
  always_comb begin
    w_luh = ex_memread &
            ((id_rs_valid & (id_rs == ex_rd)) | (id_rt_valid & (id_rt == ex_rd)));
    w_stall_max = &r_stall_cnt;
    w_flush_max = &r_flush_cnt;
  end

  // State, flush down-counter and saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_frem      <= 3'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (halt_req) begin
            r_state <= S_HALT;
          end else if (br_taken) begin
            if (!w_flush_max) r_flush_cnt <= r_flush_cnt + 1'b1;
            if (FLUSH_CYCLES > 1) begin
              r_state <= S_FLUSH;
              r_frem  <= FREM_INIT;
            end
          end else if (w_luh) begin
            if (!w_stall_max) r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (halt_req) begin
            r_state <= S_HALT;
            r_frem  <= 3'd0;
          end else if (r_frem <= 3'd1) begin
            r_state <= S_RUN;
            r_frem  <= 3'd0;
          end else begin
            r_frem <= r_frem - 3'd1;
          end
        end
        S_HALT: begin
          if (resume) r_state <= S_RUN;
        end
        default: begin
          r_state <= S_RUN;
          r_frem  <= 3'd0;
        end
      endcase
    end
  end

  // Control outputs respond in the same cycle as the triggering input.
  always_comb begin
    pc_we     = 1'b1;
    p1_we     = 1'b1;
    p2_bubble = 1'b0;
    flush     = 1'b0;
    halted    = 1'b0;
    if (!rst_n) begin
      pc_we     = 1'b0;
      p1_we     = 1'b0;
      p2_bubble = 1'b1;
      flush     = 1'b1;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (halt_req || (!br_taken && w_luh)) begin
            pc_we     = 1'b0;
            p1_we     = 1'b0;
            p2_bubble = 1'b1;
          end else if (br_taken) begin
            flush = 1'b1;
          end
        end
        S_FLUSH: begin
          if (halt_req) begin
            pc_we     = 1'b0;
            p1_we     = 1'b0;
            p2_bubble = 1'b1;
          end else begin
            flush = 1'b1;
          end
        end
        default: begin
          pc_we     = 1'b0;
          p1_we     = 1'b0;
          p2_bubble = 1'b1;
          halted    = 1'b1;
        end
      endcase
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
